// File: rtl/uart_receiver_pkg.sv
// Shared UART receive definitions: frame state encoding and counter sizing.
package uart_receiver_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } uart_state_e;

    // Counter width for a range of n values, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_receiver_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit; reusable across UART blocks.
module sync_2ff (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_receiver.sv
// UART receive stage: start validation, mid-bit sampling on rxClk rising edges, one-cycle strobes.
//
// state    | meaning
// IDLE     | line idle, waiting for a low sample
// START    | counting to mid start bit to reject glitches
// DATA     | sampling data bits LSB first at mid-bit
// STOP     | sampling stop bit, publishing data and strobe
// BREAK    | stop bit was low; wait for line to go high
module uart_receiver
    import uart_receiver_pkg::*;
#(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rxClk,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 dataValid,
    output logic                 frameError,
    output logic                 busy
);

    localparam int unsigned TICK_W = cnt_width(OVERSAMPLE);
    localparam int unsigned BIT_W  = cnt_width(DATA_BITS);

    localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

    logic rx_sync;
    logic rx_clk_prev_q;
    logic tick;

    uart_state_e          state_q,    state_d;
    logic [TICK_W-1:0]    tick_cnt_q, tick_cnt_d;
    logic [BIT_W-1:0]     bit_idx_q,  bit_idx_d;
    logic [DATA_BITS-1:0] shift_q,    shift_d;
    logic [DATA_BITS-1:0] data_q,     data_d;
    logic                 valid_q,    valid_d;
    logic                 ferr_q,     ferr_d;

    sync_2ff u_rx_sync (
        .clk_i (clk),
        .rst_i (reset),
        .d_i   (rx),
        .q_o   (rx_sync)
    );

    assign tick = rxClk & ~rx_clk_prev_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_clk_prev_q <= 1'b0;
            state_q       <= ST_IDLE;
            tick_cnt_q    <= '0;
            bit_idx_q     <= '0;
            shift_q       <= '0;
            data_q        <= '0;
            valid_q       <= 1'b0;
            ferr_q        <= 1'b0;
        end else begin
            rx_clk_prev_q <= rxClk;
            state_q       <= state_d;
            tick_cnt_q    <= tick_cnt_d;
            bit_idx_q     <= bit_idx_d;
            shift_q       <= shift_d;
            data_q        <= data_d;
            valid_q       <= valid_d;
            ferr_q        <= ferr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        data_d     = data_q;
        valid_d    = 1'b0;
        ferr_d     = 1'b0;

        if (tick) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (!rx_sync) begin
                        state_d    = ST_START;
                        tick_cnt_d = '0;
                    end
                end
                ST_START: begin
                    tick_cnt_d = tick_cnt_q + TICK_W'(1);
                    if (tick_cnt_q == TICK_MID) begin
                        if (!rx_sync) begin
                            state_d    = ST_DATA;
                            tick_cnt_d = '0;
                            bit_idx_d  = '0;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
                ST_DATA: begin
                    tick_cnt_d = tick_cnt_q + TICK_W'(1);
                    if (tick_cnt_q == TICK_LAST) begin
                        shift_d    = {rx_sync, shift_q[DATA_BITS-1:1]};
                        tick_cnt_d = '0;
                        if (bit_idx_q == BIT_LAST) begin
                            state_d = ST_STOP;
                        end else begin
                            bit_idx_d = bit_idx_q + BIT_W'(1);
                        end
                    end
                end
                ST_STOP: begin
                    tick_cnt_d = tick_cnt_q + TICK_W'(1);
                    if (tick_cnt_q == TICK_LAST) begin
                        data_d = shift_q;
                        // Leaving at mid-stop lets an immediately following start bit be caught.
                        if (rx_sync) begin
                            valid_d = 1'b1;
                            state_d = ST_IDLE;
                        end else begin
                            ferr_d  = 1'b1;
                            state_d = ST_BREAK;
                        end
                    end
                end
                ST_BREAK: begin
                    if (rx_sync) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    assign data       = data_q;
    assign dataValid  = valid_q;
    assign frameError = ferr_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: frames are modelled as expected {stop_ok, byte} events.
module tb_uart_receiver;

    localparam int BIT_CLK = 64;  // rxClk rises every 4 clk, 16 rises per bit

    logic       clk    = 1'b0;
    logic       reset  = 1'b1;
    logic       rxClk  = 1'b0;
    logic       rx     = 1'b1;
    logic [7:0] data;
    logic       dataValid;
    logic       frameError;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int div_cnt = 0;

    logic [8:0] got_q[$];
    logic [8:0] exp_q[$];

    uart_receiver #(.DATA_BITS(8), .OVERSAMPLE(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .rxClk      (rxClk),
        .rx         (rx),
        .data       (data),
        .dataValid  (dataValid),
        .frameError (frameError),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        div_cnt = div_cnt + 1;
        if (div_cnt == 2) begin
            div_cnt = 0;
            rxClk = ~rxClk;
        end
    end

    // Every strobe cycle becomes one event; a strobe lasting two cycles yields two.
    always @(negedge clk) begin
        if (!reset) begin
            if (dataValid)  got_q.push_back({1'b1, data});
            if (frameError) got_q.push_back({1'b0, data});
        end
    end

    task automatic send_bit(input logic b, input int n_clk);
        rx = b;
        repeat (n_clk) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] byte_v, input logic stop_ok);
        exp_q.push_back({stop_ok, byte_v});
        send_bit(1'b0, BIT_CLK);
        for (int i = 0; i < 8; i++) send_bit(byte_v[i], BIT_CLK);
        send_bit(stop_ok, BIT_CLK);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        rx    = 1'b1;
        repeat (5) @(negedge clk);
        checks++; if (data !== 8'h00)    begin errors++; $display("FAIL reset_data got %h exp 00", data); end
        checks++; if (dataValid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", dataValid); end
        checks++; if (frameError !== 1'b0) begin errors++; $display("FAIL reset_ferr got %b exp 0", frameError); end
        checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        reset = 1'b0;
        repeat (BIT_CLK) @(negedge clk);
    endtask

    task automatic test_glitch;
        got_q.delete(); exp_q.delete();
        send_bit(1'b0, 16);
        send_bit(1'b1, 2 * BIT_CLK);
        checks++; if (got_q.size() != 0) begin errors++; $display("FAIL glitch_events got %0d exp 0", got_q.size()); end
        checks++; if (data !== 8'h00)   begin errors++; $display("FAIL glitch_data got %h exp 00", data); end
        checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL glitch_busy got %b exp 0", busy); end
    endtask

    task automatic test_good_frame;
        got_q.delete(); exp_q.delete();
        send_frame(8'hA5, 1'b1);
        send_bit(1'b1, 2 * BIT_CLK);
        checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL good_count got %0d exp %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL good_event%0d got %h exp %h", i, got_q[i], exp_q[i]); end
        end
        checks++; if (data !== 8'hA5) begin errors++; $display("FAIL good_data got %h exp a5", data); end
        checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL good_busy got %b exp 0", busy); end
    endtask

    task automatic test_break;
        got_q.delete(); exp_q.delete();
        send_frame(8'h3C, 1'b0);
        send_bit(1'b0, 3 * BIT_CLK);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL break_busy_held got %b exp 1", busy); end
        send_bit(1'b1, 2 * BIT_CLK);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL break_busy_exit got %b exp 0", busy); end
        checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL break_count got %0d exp %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL break_event%0d got %h exp %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_back_to_back;
        got_q.delete(); exp_q.delete();
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_bit(1'b1, 2 * BIT_CLK);
        checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL b2b_count got %0d exp %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_event%0d got %h exp %h", i, got_q[i], exp_q[i]); end
        end
        checks++; if (data !== 8'hFF) begin errors++; $display("FAIL b2b_data got %h exp ff", data); end
    endtask

    task automatic test_reset_mid;
        logic [7:0] partial;
        got_q.delete(); exp_q.delete();
        partial = 8'h9E;
        send_bit(1'b0, BIT_CLK);
        for (int i = 0; i < 4; i++) send_bit(partial[i], BIT_CLK);
        send_bit(partial[4], BIT_CLK / 2);
        reset = 1'b1;
        #1;
        checks++; if (data !== 8'h00)      begin errors++; $display("FAIL rstmid_data got %h exp 00", data); end
        checks++; if (dataValid !== 1'b0)  begin errors++; $display("FAIL rstmid_valid got %b exp 0", dataValid); end
        checks++; if (frameError !== 1'b0) begin errors++; $display("FAIL rstmid_ferr got %b exp 0", frameError); end
        checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL rstmid_busy got %b exp 0", busy); end
        rx = 1'b1;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        send_bit(1'b1, 2 * BIT_CLK);
        checks++; if (got_q.size() != 0) begin errors++; $display("FAIL rstmid_partial got %0d events exp 0", got_q.size()); end
        send_frame(8'h55, 1'b1);
        send_bit(1'b1, 2 * BIT_CLK);
        checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL rstmid_count got %0d exp %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rstmid_event%0d got %h exp %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_random;
        logic [7:0] b;
        logic       ok;
        logic [7:0] last;
        got_q.delete(); exp_q.delete();
        last = data;
        for (int n = 0; n < 8; n++) begin
            b  = 8'($urandom_range(0, 255));
            ok = ($urandom_range(0, 3) != 0);
            send_frame(b, ok);
            last = b;
            if (!ok) send_bit(1'b1, BIT_CLK);
            else     send_bit(1'b1, $urandom_range(0, 20));
        end
        send_bit(1'b1, 2 * BIT_CLK);
        checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL rand_count got %0d exp %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand_event%0d got %h exp %h", i, got_q[i], exp_q[i]); end
        end
        checks++; if (data !== last) begin errors++; $display("FAIL rand_data_hold got %h exp %h", data, last); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rand_busy got %b exp 0", busy); end
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_good_frame();
        test_break();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
